// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit pipeline: default widths and the MEM/WB buffer record.
package pipeline_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_REG_W  = 3;

  typedef struct packed {
    logic                  valid;
    logic                  mem_to_reg;
    logic [DEF_DATA_W-1:0] mem_data;
    logic [DEF_DATA_W-1:0] alu_result;
    logic                  wb;
    logic [DEF_REG_W-1:0]  dest;
  } mem_wb_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with wrap detection, optional wrap suppression (guard) and sticky stack_err.
module stack_pointer_unit #(
  parameter int ADDR_W = pipeline_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              push,
  input  logic              pop,
  input  logic              guard,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_inc,
  output logic              blocked,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] SP_TOP = '1;

  logic do_push;
  logic do_pop;
  logic wrap;

  // push outranks pop when both strobes are raised together
  assign do_push = enable & push;
  assign do_pop  = enable & ~push & pop;
  assign sp_inc  = sp + 1'b1;
  assign wrap    = (do_push && sp == '0) || (do_pop && sp == SP_TOP);
  assign blocked = guard & wrap;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= SP_TOP;
      stack_err <= 1'b0;
    end else begin
      if (wrap) stack_err <= 1'b1;
      if (!blocked) begin
        if (do_push)     sp <= sp - 1'b1;
        else if (do_pop) sp <= sp_inc;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: data memory, stack pointer and MEM/WB buffer; one cycle EX -> WB.
// Build option: define MEM_STACK_GUARD_EN to suppress wrapping pushes/pops instead of wrapping.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_push,
  input  logic              ex_pop,
  input  logic              ex_wb,
  input  logic [REG_W-1:0]  ex_dest,
  output logic              wb_valid,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_dest,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_err
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef MEM_STACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sp_inc;
  logic              active;
  logic              blocked;
  logic              do_push, do_pop, do_store, do_load;
  mem_wb_t           wb_q, wb_d;

  assign addr   = ex_result[ADDR_W-1:0];
  assign active = ex_valid & ~stall & ~flush;

  stack_pointer_unit #(.ADDR_W(ADDR_W)) u_sp (
    .clk       (clk),
    .reset     (reset),
    .enable    (active),
    .push      (ex_push),
    .pop       (ex_pop),
    .guard     (GUARD),
    .sp        (sp),
    .sp_inc    (sp_inc),
    .blocked   (blocked),
    .stack_err (stack_err)
  );

  // Priority push > pop > store > load; a guarded wrap cancels the stack op.
  assign do_push  = active & ex_push & ~blocked;
  assign do_pop   = active & ~ex_push & ex_pop & ~blocked;
  assign do_store = active & ~ex_push & ~ex_pop & ex_mem_write;
  assign do_load  = active & ~ex_push & ~ex_pop & ~ex_mem_write & ex_mem_read;

  // NOTE: the memory array has no reset; only the write is gated so that an
  // edge seen while reset is high never corrupts a word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_push)       mem[sp]   <= ex_store_data;
      else if (do_store) mem[addr] <= ex_store_data;
    end
  end

  // Reads are taken from the array after the previous edge's write has landed,
  // so a load right behind a store to the same word sees the new data.
  // NOTE: wb_d starts from wb_q so every field has a value on every path and
  // no latch is inferred.
  always_comb begin
    wb_d            = wb_q;
    wb_d.valid      = ex_valid & ~flush & ~blocked;
    wb_d.mem_to_reg = do_pop | do_load;
    wb_d.alu_result = ex_result;
    wb_d.wb         = ex_wb;
    wb_d.dest       = ex_dest;
    if (do_pop)       wb_d.mem_data = mem[sp_inc];
    else if (do_load) wb_d.mem_data = mem[addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       wb_q <= '0;
    else if (!stall) wb_q <= wb_d;
  end

  assign wb_valid      = wb_q.valid;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_mem_data   = wb_q.mem_data;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_en         = wb_q.valid & wb_q.wb;
  assign wb_dest       = wb_q.dest;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized traffic vs a behavioural model.
module tb_mem_access_stage;

  localparam int DEPTH = 1024;
`ifdef MEM_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_valid;
  logic [15:0] ex_result, ex_store_data;
  logic        ex_mem_read, ex_mem_write, ex_push, ex_pop, ex_wb;
  logic [2:0]  ex_dest;
  logic        wb_valid, wb_mem_to_reg, wb_en, stack_err;
  logic [15:0] wb_mem_data, wb_alu_result;
  logic [2:0]  wb_dest;
  logic [9:0]  sp;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_mem [DEPTH];
  int          m_sp;
  bit          m_err;
  bit          e_valid, e_m2r, e_wb;
  logic [15:0] e_mdata, e_alu;
  logic [2:0]  e_dest;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_push       (ex_push),
    .ex_pop        (ex_pop),
    .ex_wb         (ex_wb),
    .ex_dest       (ex_dest),
    .wb_valid      (wb_valid),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .sp            (sp),
    .stack_err     (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sp    = DEPTH - 1;
    m_err   = 1'b0;
    e_valid = 1'b0;
    e_m2r   = 1'b0;
    e_wb    = 1'b0;
    e_mdata = '0;
    e_alu   = '0;
    e_dest  = '0;
  endtask

  // Applies one clock edge of the spec's rules to the model, using the currently driven inputs.
  task automatic model_step();
    int  a;
    int  nsp;
    bit  act;
    if (stall) return;
    a       = int'(ex_result[9:0]);
    act     = ex_valid && !flush;
    e_valid = act;
    e_m2r   = 1'b0;
    e_alu   = ex_result;
    e_wb    = ex_wb;
    e_dest  = ex_dest;
    if (!act) return;
    if (ex_push) begin
      nsp = (m_sp + DEPTH - 1) % DEPTH;
      if (m_sp == 0) m_err = 1'b1;
      if (GUARD && m_sp == 0) e_valid = 1'b0;
      else begin
        m_mem[m_sp] = ex_store_data;
        m_sp        = nsp;
      end
    end else if (ex_pop) begin
      nsp = (m_sp + 1) % DEPTH;
      if (m_sp == DEPTH - 1) m_err = 1'b1;
      if (GUARD && m_sp == DEPTH - 1) e_valid = 1'b0;
      else begin
        e_mdata = m_mem[nsp];
        e_m2r   = 1'b1;
        m_sp    = nsp;
      end
    end else if (ex_mem_write) begin
      m_mem[a] = ex_store_data;
    end else if (ex_mem_read) begin
      e_mdata = m_mem[a];
      e_m2r   = 1'b1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"},    32'(wb_valid),      32'(e_valid));
    check({tag, ".m2r"},      32'(wb_mem_to_reg), 32'(e_m2r));
    check({tag, ".mem_data"}, 32'(wb_mem_data),   32'(e_mdata));
    check({tag, ".alu"},      32'(wb_alu_result), 32'(e_alu));
    check({tag, ".en"},       32'(wb_en),         32'(e_valid & e_wb));
    check({tag, ".dest"},     32'(wb_dest),       32'(e_dest));
    check({tag, ".sp"},       32'(sp),            32'(m_sp));
    check({tag, ".err"},      32'(stack_err),     32'(m_err));
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; ex_valid = 0; ex_result = '0; ex_store_data = '0;
    ex_mem_read = 0; ex_mem_write = 0; ex_push = 0; ex_pop = 0; ex_wb = 0; ex_dest = '0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    model_step();
    compare_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    model_reset();
    check("rst.valid", 32'(wb_valid), 32'd0);
    check("rst.en",    32'(wb_en),    32'd0);
    check("rst.data",  32'(wb_mem_data), 32'd0);
    check("rst.sp",    32'(sp),       32'd1023);
    check("rst.err",   32'(stack_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill every word through stores so the model knows the whole array.
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      ex_valid = 1; ex_mem_write = 1; ex_result = 16'(i); ex_store_data = 16'(i) ^ 16'hA5A5;
      tick("fill");
    end
    do_reset();

    // Push 0x1234 then pop into r3.
    idle_inputs();
    ex_valid = 1; ex_push = 1; ex_store_data = 16'h1234;
    tick("push");
    check("push.sp", 32'(sp), 32'd1022);
    idle_inputs();
    ex_valid = 1; ex_pop = 1; ex_wb = 1; ex_dest = 3'd3;
    tick("pop");
    check("pop.data", 32'(wb_mem_data), 32'h1234);
    check("pop.dest", 32'(wb_dest), 32'd3);
    check("pop.en",   32'(wb_en), 32'd1);
    check("pop.sp",   32'(sp), 32'd1023);

    // Store 0xBEEF at 5, load it back the next cycle.
    idle_inputs();
    ex_valid = 1; ex_mem_write = 1; ex_result = 16'd5; ex_store_data = 16'hBEEF;
    tick("store");
    idle_inputs();
    ex_valid = 1; ex_mem_read = 1; ex_result = 16'd5; ex_wb = 1; ex_dest = 3'd1;
    tick("load");
    check("load.data", 32'(wb_mem_data), 32'hBEEF);
    check("load.m2r",  32'(wb_mem_to_reg), 32'd1);

    // Push held by stall for three cycles, then released.
    idle_inputs();
    ex_valid = 1; ex_push = 1; ex_store_data = 16'h5A5A; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall.sp", 32'(sp), 32'd1023);
    end
    stall = 0;
    tick("stall_rel");
    check("stall_rel.sp", 32'(sp), 32'd1022);
    idle_inputs();
    ex_valid = 1; ex_pop = 1;
    tick("stall_pop");
    check("stall_pop.data", 32'(wb_mem_data), 32'h5A5A);
    check("stall_pop.sp",   32'(sp), 32'd1023);

    // Flush of a valid ALU op.
    idle_inputs();
    ex_valid = 1; ex_wb = 1; ex_dest = 3'd2; ex_result = 16'h0077; flush = 1;
    tick("flush");
    check("flush.valid", 32'(wb_valid), 32'd0);
    check("flush.en",    32'(wb_en), 32'd0);
    check("flush.sp",    32'(sp), 32'd1023);

    // Pop at reset SP.
    idle_inputs();
    do_reset();
    ex_valid = 1; ex_pop = 1; ex_wb = 1; ex_dest = 3'd4;
    tick("popwrap");
`ifdef MEM_STACK_GUARD_EN
    check("popwrap.sp",    32'(sp), 32'd1023);
    check("popwrap.valid", 32'(wb_valid), 32'd0);
`else
    check("popwrap.sp",    32'(sp), 32'd0);
    check("popwrap.valid", 32'(wb_valid), 32'd1);
`endif
    check("popwrap.err", 32'(stack_err), 32'd1);

    // Asynchronous reset in the middle of a store to word 7.
    idle_inputs();
    ex_valid = 1; ex_mem_write = 1; ex_result = 16'd7; ex_store_data = 16'hDEAD;
    #2;
    reset = 1'b1;
    #1;
    check("arst.valid", 32'(wb_valid), 32'd0);
    check("arst.m2r",   32'(wb_mem_to_reg), 32'd0);
    check("arst.data",  32'(wb_mem_data), 32'd0);
    check("arst.alu",   32'(wb_alu_result), 32'd0);
    check("arst.en",    32'(wb_en), 32'd0);
    check("arst.dest",  32'(wb_dest), 32'd0);
    check("arst.sp",    32'(sp), 32'd1023);
    check("arst.err",   32'(stack_err), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    ex_valid = 1; ex_mem_read = 1; ex_result = 16'd7;
    tick("arst_load");
    check("arst_load.data", 32'(wb_mem_data), 32'hA5A2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 9) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      ex_valid      = ($urandom_range(0, 9) != 0);
      ex_push       = ($urandom_range(0, 3) == 0);
      ex_pop        = ($urandom_range(0, 3) == 0);
      ex_mem_write  = ($urandom_range(0, 2) == 0);
      ex_mem_read   = ($urandom_range(0, 1) == 0);
      ex_wb         = 1'($urandom);
      ex_dest       = 3'($urandom);
      ex_result     = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      ex_store_data = 16'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
